// File: rtl/sync_fifo_ram_pkg.sv
// Shared definitions for the parametrised RAM-backed synchronous FIFO:
// default geometry, operation encoding and parameter legality helpers.
package sync_fifo_ram_pkg;

   localparam int DEF_WID   = 138;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_AWID  = 5;
   localparam int DEF_AFULL = 28;

   // Accepted operations in one cycle, encoded as {push, pop}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      while ((32'sd1 <<< result) < value) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
   endfunction

   function automatic bit fifo_params_ok(input int depth, input int awid, input int afull);
      return (depth >= 32'sd4) && is_pow2(depth) && (awid == clog2(depth)) &&
             (afull >= 32'sd1) && (afull <= depth);
   endfunction

endpackage

// File: rtl/sync_fifo_ram_if.sv
// Push/pop handshake, flush and status bundle of the synchronous FIFO.
interface sync_fifo_ram_if #(
   parameter int WID  = 138,
   parameter int AWID = 5
);
   logic            softreset;
   logic            writein;
   logic [WID-1:0]  din;
   logic            readin;
   logic [WID-1:0]  dout;
   logic            dout_vld;
   logic            full;
   logic            empty;
   logic            almost_full;
   logic [AWID:0]   count;
   logic            overflow;
   logic            underflow;

   modport master (
      output softreset, writein, din, readin,
      input  dout, dout_vld, full, empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  softreset, writein, din, readin,
      output dout, dout_vld, full, empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ram_ram2p_wd.sv
// Generic two-port RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module ram2p_wd #(
   parameter int WID   = 138,
   parameter int DEPTH = 32,
   parameter int AWID  = 5
) (
   input  logic            clk,
   input  logic            wen,
   input  logic [AWID-1:0] waddr,
   input  logic [WID-1:0]  wdata,
   input  logic            ren,
   input  logic [AWID-1:0] raddr,
   output logic [WID-1:0]  rdata
);

   logic [WID-1:0] mem_r [DEPTH];

   // Array write; no reset so the array maps onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read sampling pre-write contents; holds when not enabled.
   always_ff @(posedge clk) begin
      if (ren) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo_ram.sv
// Parametrised synchronous FIFO on a two-port RAM with flow control,
// occupancy count, almost-full threshold, sticky error flags and flush.
module sync_fifo_ram
   import sync_fifo_ram_pkg::*;
#(
   parameter int WID   = DEF_WID,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AWID  = DEF_AWID,
   parameter int AFULL = DEF_AFULL
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_ram_if.slave    bus
);

   localparam logic [AWID:0] DEPTH_C = (AWID+1)'(DEPTH);
   localparam logic [AWID:0] AFULL_C = (AWID+1)'(AFULL);

   if (!fifo_params_ok(DEPTH, AWID, AFULL)) begin : g_param_err
      $error("sync_fifo_ram: illegal DEPTH/AWID/AFULL combination");
   end

   logic [AWID-1:0] wptr_r;
   logic [AWID-1:0] rptr_r;
   logic [AWID:0]   count_r;
   logic            empty_r;
   logic            full_r;
   logic            afull_r;
   logic            dout_vld_r;
   logic            overflow_r;
   logic            underflow_r;
   logic            primed_r;

   logic            wr_req_s;
   logic            rd_req_s;
   logic            flush_s;
   logic            wr_acc_s;
   logic            rd_acc_s;
   logic [AWID:0]   count_nxt_s;
   fifo_op_e        op_s;
   logic [WID-1:0]  rdata_s;

   // Request qualification: an unknown control input falls to the else branch and becomes a no-op.
   always_comb begin
      wr_req_s = 1'b0;
      rd_req_s = 1'b0;
      flush_s  = 1'b0;
      if (bus.softreset == 1'b1) begin
         flush_s = 1'b1;
      end else begin
         flush_s = 1'b0;
      end
      if ((bus.writein == 1'b1) && !flush_s) begin
         wr_req_s = 1'b1;
      end else begin
         wr_req_s = 1'b0;
      end
      if ((bus.readin == 1'b1) && !flush_s) begin
         rd_req_s = 1'b1;
      end else begin
         rd_req_s = 1'b0;
      end
   end

   // Acceptance and next occupancy; a full FIFO takes a push only alongside a pop.
   always_comb begin
      rd_acc_s    = rd_req_s && !empty_r;
      wr_acc_s    = wr_req_s && (!full_r || rd_acc_s);
      op_s        = fifo_op_e'({wr_acc_s, rd_acc_s});
      count_nxt_s = count_r;
      case (op_s)
         OP_PUSH: count_nxt_s = count_r + (AWID+1)'(1);
         OP_POP:  count_nxt_s = count_r - (AWID+1)'(1);
         OP_BOTH: count_nxt_s = count_r;
         OP_IDLE: count_nxt_s = count_r;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy, flags and sticky errors; flags follow the next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r      <= '0;
         rptr_r      <= '0;
         count_r     <= '0;
         empty_r     <= 1'b1;
         full_r      <= 1'b0;
         afull_r     <= 1'b0;
         dout_vld_r  <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         primed_r    <= 1'b0;
      end else if (flush_s) begin
         wptr_r      <= '0;
         rptr_r      <= '0;
         count_r     <= '0;
         empty_r     <= 1'b1;
         full_r      <= 1'b0;
         afull_r     <= 1'b0;
         dout_vld_r  <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wptr_r <= wptr_r + AWID'(1);
         end
         if (rd_acc_s) begin
            rptr_r   <= rptr_r + AWID'(1);
            primed_r <= 1'b1;
         end
         count_r    <= count_nxt_s;
         empty_r    <= (count_nxt_s == (AWID+1)'(0));
         full_r     <= (count_nxt_s == DEPTH_C);
         afull_r    <= (count_nxt_s >= AFULL_C);
         dout_vld_r <= rd_acc_s;
         if (wr_req_s && !wr_acc_s) begin
            overflow_r <= 1'b1;
         end
         if (rd_req_s && empty_r) begin
            underflow_r <= 1'b1;
         end
      end
   end

   ram2p_wd #(
      .WID   (WID),
      .DEPTH (DEPTH),
      .AWID  (AWID)
   ) u_ram (
      .clk   (clk),
      .wen   (wr_acc_s),
      .waddr (wptr_r),
      .wdata (bus.din),
      .ren   (rd_acc_s),
      .raddr (rptr_r),
      .rdata (rdata_s)
   );

   // The RAM output register is not reset, so dout reads zero until the first pop lands.
   assign bus.dout        = primed_r ? rdata_s : {WID{1'b0}};
   assign bus.dout_vld    = dout_vld_r;
   assign bus.full        = full_r;
   assign bus.empty       = empty_r;
   assign bus.almost_full = afull_r;
   assign bus.count       = count_r;
   assign bus.overflow    = overflow_r;
   assign bus.underflow   = underflow_r;

endmodule

// File: doc/sync_fifo_ram.md
Name: sync_fifo_ram

Overview:
- Parametrised synchronous FIFO built on a generic two-port RAM (one write port, one read port, registered read).
- Supersedes the fixed-size single-port RAM macros (width/depth hard-coded) as the standard buffer in the AXI/UART debug datapaths.
- Adds flow control, occupancy count, almost-full threshold, sticky error flags and a synchronous flush.
- Read data has 1-cycle latency and is held stable between pops.

Parameters:
- WID, 138, data width in bits.
- DEPTH, 32, number of entries; must be a power of two, >= 4.
- AWID, 5, address width; must equal log2(DEPTH).
- AFULL, 28, almost_full asserts when count >= AFULL; range 1..DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- softreset  input  1  synchronous flush; empties FIFO and clears error flags.
- writein  input  1  push request.
- din  input  WID  push data.
- readin  input  1  pop request.
- dout  output  WID  popped data; valid the cycle after an accepted pop, held until the next pop.
- dout_vld  output  1  one-cycle pulse, aligned with new dout.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL.
- count  output  AWID+1  current occupancy.
- overflow  output  1  sticky; a push was dropped.
- underflow  output  1  sticky; a pop was rejected.

Behaviour:
- Reset (rst_n low, async): wptr=0, rptr=0, count=0, empty=1, full=0, almost_full=0, dout_vld=0, dout=0, overflow=0, underflow=0. RAM contents are not cleared.
- Accepting a pop: rd_acc = readin && !empty.
- Accepting a push: wr_acc = writein && (!full || rd_acc).
  - A push while full is accepted only if a pop is accepted in the same cycle.
- Rejections:
  - writein && !wr_acc: push dropped, pointers unchanged, overflow <= 1.
  - readin && empty: no pop, underflow <= 1, dout_vld stays 0. This applies even if a push occurs in the same cycle; no write-to-read bypass.
- Pointer updates:
  - wr_acc: RAM[wptr] <= din; wptr <= wptr+1, wrapping modulo DEPTH.
  - rd_acc: RAM read of rptr; rptr <= rptr+1, wrapping modulo DEPTH.
- Count update: count <= count + wr_acc - rd_acc. Flags are registered and derived from the next count, so they are correct in the same cycle count updates.
- Pop latency: an accepted pop in cycle N gives dout = RAM[rptr_N] and dout_vld=1 in cycle N+1. With no pop, dout holds its value and dout_vld=0.
- Full + simultaneous push/pop: wptr == rptr, so the read and write hit the same address. The read must return the OLD contents (read-before-write); count stays DEPTH.
- Simultaneous push/pop at count 1..DEPTH-1: count unchanged, both pointers advance.
- softreset (synchronous, priority over push/pop in that cycle):
  - wptr, rptr, count cleared; empty=1, full=0, almost_full=0.
  - overflow and underflow cleared; dout_vld=0.
  - dout holds its value.
- rst_n asserted mid-burst: everything returns to reset values immediately. A pop pending from the previous cycle produces no dout_vld.
- Simulation X-guard: X on writein, readin or softreset (while rst_n high) forces the FIFO to treat the cycle as no-op and flags it with $display; synthesis ignores this.

Decomposition:
- Shared package:
  - clog2 helper function.
  - Parameter legality checks, asserted at elaboration: DEPTH power of two, AWID == clog2(DEPTH), 1 <= AFULL <= DEPTH.
- Sub-module ram2p_wd (params WID, DEPTH, AWID):
  - Ports: clk, wen, waddr, wdata, ren, raddr, rdata.
  - Registered read; rdata holds its last value when ren=0.
  - Read-before-write on same-address collision.
  - No reset on the array.
- FIFO control (pointers, count, flags, error bits) lives in sync_fifo_ram.

Test Plan:
- Fill/drain: push 32 words 0..31 with no pops.
  - After push 28: almost_full=1. After push 32: full=1, count=32.
  - Then 32 back-to-back pops: dout=0..31 in order, one dout_vld per cycle, 1 cycle after each pop; finally empty=1.
- Overflow: at count=32, push 0xAA alone -> dropped, overflow=1, count=32. The next pop returns the oldest word, not 0xAA.
- Full collision: at count=32, push 0x55 and pop in the same cycle -> next-cycle dout = oldest entry, count stays 32. Draining 32 pops returns 0x55 last.
- Underflow: pop at empty, together with push 0x7 -> dout_vld=0, underflow=1, count=1. The next pop returns 0x7.
- Wrap-around: 100 cycles of random push/pop with occupancy kept at 3..30 -> dout matches a reference queue model; count, full and empty correct every cycle.
- Flush/reset: at count=10 with overflow=1, assert softreset for 1 cycle -> count=0, empty=1, overflow=0, dout unchanged. Assert rst_n low mid-burst -> all outputs at reset values within the same cycle.
